// File: rtl/adc_serial_capture.sv
// Serial ADC frame capture (CS_n/SCLK/SDATA) gated by PLL lock, with valid/ready sample output.
// Define ADC_TEST_PATTERN_EN to replace captured data with the zero-extended frame sequence number.
module adc_serial_capture #(
    parameter int unsigned SCLK_DIV      = 2,
    parameter int unsigned FRAME_BITS    = 16,
    parameter int unsigned DATA_BITS     = 12,
    parameter int unsigned QUIET_CYC     = 4,
    parameter int unsigned SAMPLE_PERIOD = 96,
    parameter int unsigned LOCK_WAIT     = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pll_lock,
    output logic                 adc_cs_n,
    output logic                 adc_sclk,
    input  logic                 adc_sdata,
    output logic [DATA_BITS-1:0] sample_data,
    output logic [7:0]           sample_seq,
    output logic                 sample_valid,
    input  logic                 sample_ready,
    output logic                 overrun,
    input  logic                 overrun_clr,
    output logic                 running
);

    localparam int unsigned MinPeriod = 1 + 2 * SCLK_DIV * FRAME_BITS + QUIET_CYC;

    if (SAMPLE_PERIOD < MinPeriod) begin : g_bad_period
        $error("SAMPLE_PERIOD too short for one frame plus quiet time");
    end
    if (SCLK_DIV < 1 || QUIET_CYC < 1 || LOCK_WAIT < 1) begin : g_bad_timing
        $error("SCLK_DIV, QUIET_CYC and LOCK_WAIT must be at least 1");
    end
    if (DATA_BITS < 2 || DATA_BITS > FRAME_BITS) begin : g_bad_width
        $error("DATA_BITS must be in 2..FRAME_BITS");
    end

    localparam int unsigned PhaseW  = $clog2(SCLK_DIV + 1);
    localparam int unsigned BitW    = $clog2(FRAME_BITS + 1);
    localparam int unsigned TimerW  = $clog2(LOCK_WAIT + QUIET_CYC + 1);
    localparam int unsigned PeriodW = $clog2(SAMPLE_PERIOD + 1);

    localparam logic [PhaseW-1:0]  PhaseLast  = PhaseW'(SCLK_DIV - 1);
    localparam logic [BitW-1:0]    BitsDone   = BitW'(FRAME_BITS);
    localparam logic [TimerW-1:0]  SettleLast = TimerW'(LOCK_WAIT - 1);
    localparam logic [TimerW-1:0]  QuietLast  = TimerW'(QUIET_CYC - 1);
    localparam logic [PeriodW-1:0] PeriodLast = PeriodW'(SAMPLE_PERIOD - 1);

    typedef enum logic [2:0] {StWaitLock, StSettle, StIdle, StConv, StQuiet} state_e;

    state_e               state_q, state_d;
    logic                 lock_s1_q, lock_s2_q, sdata_q;
    logic                 cs_n_q, cs_n_d, sclk_q, sclk_d;
    logic [PhaseW-1:0]    phase_q, phase_d;
    logic [BitW-1:0]      bit_q, bit_d;
    logic [TimerW-1:0]    timer_q, timer_d;
    logic [PeriodW-1:0]   period_q, period_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [7:0]           frame_seq_q, frame_seq_d;
    logic [DATA_BITS-1:0] sample_data_q, sample_data_d;
    logic [7:0]           sample_seq_q, sample_seq_d;
    logic                 valid_q, valid_d, overrun_q, overrun_d;
    logic                 sample_done, drop;
    logic [DATA_BITS-1:0] captured;

    logic lock_sync;
    assign lock_sync = lock_s2_q;

    always_comb begin
        state_d     = state_q;
        cs_n_d      = cs_n_q;
        sclk_d      = sclk_q;
        phase_d     = phase_q;
        bit_d       = bit_q;
        timer_d     = timer_q;
        shift_d     = shift_q;
        sample_done = 1'b0;
        period_d    = (period_q == PeriodLast) ? period_q : period_q + PeriodW'(1);

        if (!lock_sync) begin
            // Lock loss aborts any partial frame; the output register is untouched.
            state_d = StWaitLock;
            cs_n_d  = 1'b1;
            sclk_d  = 1'b1;
        end else begin
            unique case (state_q)
                StWaitLock: begin
                    // The cycle that sees lock counts as the first settle cycle.
                    state_d = StSettle;
                    timer_d = TimerW'(1);
                end
                StSettle: begin
                    if (timer_q >= SettleLast) begin
                        state_d  = StIdle;
                        period_d = PeriodLast;
                    end else begin
                        timer_d = timer_q + TimerW'(1);
                    end
                end
                StIdle: begin
                    if (period_q == PeriodLast) begin
                        state_d  = StConv;
                        cs_n_d   = 1'b0;
                        sclk_d   = 1'b1;
                        phase_d  = PhaseLast;
                        bit_d    = '0;
                        period_d = '0;
                    end
                end
                StConv: begin
                    if (bit_q == BitsDone) begin
                        state_d     = StQuiet;
                        cs_n_d      = 1'b1;
                        sclk_d      = 1'b1;
                        timer_d     = '0;
                        sample_done = 1'b1;
                    end else if (phase_q == PhaseLast) begin
                        phase_d = '0;
                        sclk_d  = ~sclk_q;
                        if (!sclk_q) begin
                            shift_d = {shift_q[DATA_BITS-2:0], sdata_q};
                            bit_d   = bit_q + BitW'(1);
                        end
                    end else begin
                        phase_d = phase_q + PhaseW'(1);
                    end
                end
                StQuiet: begin
                    if (timer_q == QuietLast) begin
                        state_d = StIdle;
                    end else begin
                        timer_d = timer_q + TimerW'(1);
                    end
                end
                default: state_d = StWaitLock;
            endcase
        end
    end

`ifdef ADC_TEST_PATTERN_EN
    logic unused_shift;
    assign unused_shift = ^shift_q;
    always_comb captured = DATA_BITS'(frame_seq_q);
`else
    always_comb captured = shift_q;
`endif

    always_comb begin
        frame_seq_d   = frame_seq_q;
        sample_data_d = sample_data_q;
        sample_seq_d  = sample_seq_q;
        valid_d       = valid_q;
        drop          = 1'b0;

        if (valid_q && sample_ready) begin
            valid_d = 1'b0;
        end
        if (sample_done) begin
            // Sequence advances even on a drop so the host can see the gap.
            frame_seq_d = frame_seq_q + 8'd1;
            if (!valid_q || sample_ready) begin
                sample_data_d = captured;
                sample_seq_d  = frame_seq_q;
                valid_d       = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end
        overrun_d = (overrun_q & ~overrun_clr) | drop;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StWaitLock;
            lock_s1_q     <= 1'b0;
            lock_s2_q     <= 1'b0;
            sdata_q       <= 1'b0;
            cs_n_q        <= 1'b1;
            sclk_q        <= 1'b1;
            phase_q       <= '0;
            bit_q         <= '0;
            timer_q       <= '0;
            period_q      <= '0;
            shift_q       <= '0;
            frame_seq_q   <= '0;
            sample_data_q <= '0;
            sample_seq_q  <= '0;
            valid_q       <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            lock_s1_q     <= pll_lock;
            lock_s2_q     <= lock_s1_q;
            sdata_q       <= adc_sdata;
            cs_n_q        <= cs_n_d;
            sclk_q        <= sclk_d;
            phase_q       <= phase_d;
            bit_q         <= bit_d;
            timer_q       <= timer_d;
            period_q      <= period_d;
            shift_q       <= shift_d;
            frame_seq_q   <= frame_seq_d;
            sample_data_q <= sample_data_d;
            sample_seq_q  <= sample_seq_d;
            valid_q       <= valid_d;
            overrun_q     <= overrun_d;
        end
    end

    assign adc_cs_n     = cs_n_q;
    assign adc_sclk     = sclk_q;
    assign sample_data  = sample_data_q;
    assign sample_seq   = sample_seq_q;
    assign sample_valid = valid_q;
    assign overrun      = overrun_q;
    assign running      = (state_q == StIdle) || (state_q == StConv) || (state_q == StQuiet);

endmodule

// File: tb/tb_adc_serial_capture.sv
// Scoreboard bench for adc_serial_capture: ADC shift-out model, expected samples queued per frame.
module tb_adc_serial_capture;

    localparam int LW     = 1024;
    localparam int PERIOD = 96;

    logic        clk = 1'b0;
    logic        reset, pll_lock, adc_sdata, sample_ready, overrun_clr;
    logic        adc_cs_n, adc_sclk, sample_valid, overrun, running;
    logic [11:0] sample_data;
    logic [7:0]  sample_seq;

    adc_serial_capture dut (
        .clk          (clk),
        .reset        (reset),
        .pll_lock     (pll_lock),
        .adc_cs_n     (adc_cs_n),
        .adc_sclk     (adc_sclk),
        .adc_sdata    (adc_sdata),
        .sample_data  (sample_data),
        .sample_seq   (sample_seq),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun),
        .overrun_clr  (overrun_clr),
        .running      (running)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  seq;
        logic [11:0] data;
    } exp_t;

    exp_t        sb[$];
    int          act_q[$];   // per-frame action: 0 deliver, 1 dropped (seq advances), 2 aborted
    logic [7:0]  exp_seq = 8'd0;
    logic [15:0] adc_word;
    logic [15:0] adc_shreg = 16'h0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          act;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // ADC model: word latched on CS_n fall, MSB presented after each SCLK fall.
    always @(negedge adc_cs_n) adc_shreg = adc_word;
    always @(negedge adc_sclk) begin
        adc_sdata = adc_shreg[15];
        adc_shreg = {adc_shreg[14:0], 1'b0};
    end

    // Expected-response producer: one entry per frame as it starts.
    always @(negedge adc_cs_n) begin
        if (!reset) begin
            act = (act_q.size() > 0) ? act_q.pop_front() : 0;
            if (act == 0) begin
`ifdef ADC_TEST_PATTERN_EN
                sb.push_back({exp_seq, 4'h0, exp_seq});
`else
                sb.push_back({exp_seq, adc_word[11:0]});
`endif
                exp_seq = exp_seq + 8'd1;
            end else if (act == 1) begin
                exp_seq = exp_seq + 8'd1;
            end
        end
    end

    // Monitor: a handshake takes place at the next rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!reset && sample_valid && sample_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_sample_seq", {24'h0, sample_seq}, 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check("sample_seq", {24'h0, sample_seq}, {24'h0, e.seq});
                    check("sample_data", {20'h0, sample_data}, {20'h0, e.data});
                end
            end
        end
    end

    task automatic wait_cs_fall(output int n, input int budget);
        logic prev;
        bit   done;
        prev = adc_cs_n;
        done = 0;
        n    = 0;
        while (!done) begin
            @(posedge clk);
            #1;
            n++;
            if (prev && !adc_cs_n) begin
                done = 1;
            end else if (n >= budget) begin
                check("cs_fall_timeout", 32'd0, 32'd1);
                done = 1;
            end
            prev = adc_cs_n;
        end
    endtask

    // Called right after a CS_n fall has been observed.
    task automatic measure_frame();
        int   falls = 0;
        int   last = 0;
        int   bad_space = 0;
        logic prev_s;
        prev_s = adc_sclk;
        for (int c = 1; c <= 66; c++) begin
            @(posedge clk);
            #1;
            if (prev_s && !adc_sclk) begin
                falls++;
                if (falls == 1) check("first_sclk_fall_cycle", c, 1);
                else if (c - last != 4) bad_space++;
                last = c;
            end
            prev_s = adc_sclk;
            if (c == 63) begin
                check("cs_n_low_at_last_rise", {31'h0, adc_cs_n}, 32'd0);
                check("valid_before_latency", {31'h0, sample_valid}, 32'd0);
            end
            if (c == 64) begin
                check("cs_n_high_after_frame", {31'h0, adc_cs_n}, 32'd1);
                check("sclk_high_after_frame", {31'h0, adc_sclk}, 32'd1);
                check("valid_one_cycle_after_last_rise", {31'h0, sample_valid}, 32'd1);
            end
        end
        check("sclk_fall_count", falls, 16);
        check("sclk_pulse_spacing_errors", bad_space, 0);
    endtask

    initial begin
        int n;
        int t0;
        int c;
        int falls;
        logic prev_s;

        reset        = 1'b1;
        pll_lock     = 1'b1;
        sample_ready = 1'b1;
        overrun_clr  = 1'b0;
        adc_sdata    = 1'b0;
        adc_word     = 16'h0ABC;

        // Reset state.
        repeat (4) @(posedge clk);
        #1;
        check("reset_cs_n", {31'h0, adc_cs_n}, 32'd1);
        check("reset_sclk", {31'h0, adc_sclk}, 32'd1);
        check("reset_valid", {31'h0, sample_valid}, 32'd0);
        check("reset_overrun", {31'h0, overrun}, 32'd0);
        check("reset_running", {31'h0, running}, 32'd0);
        check("reset_seq", {24'h0, sample_seq}, 32'd0);
        check("reset_data", {20'h0, sample_data}, 32'd0);

        @(negedge clk);
        reset = 1'b0;
        wait_cs_fall(n, 2000);
        check("reset_to_first_cs_fall", n, LW + 3);
        check("running_in_conv", {31'h0, running}, 32'd1);
        t0 = cyc;
        measure_frame();

        // Frame 1 (0ABC), then frame 2 with a different word.
        wait_cs_fall(n, 200);
        check("cs_period_1", cyc - t0, PERIOD);
        t0 = cyc;
        adc_word = 16'hF555;
        wait_cs_fall(n, 200);
        check("cs_period_2", cyc - t0, PERIOD);
        measure_frame();
        adc_word = 16'h1234;

        // Frame 3 held with ready low; frames 4 and 5 dropped.
        wait_cs_fall(n, 200);
        @(negedge clk);
        sample_ready = 1'b0;
        act_q.push_back(1);
        act_q.push_back(1);
        adc_word = 16'h8E71;
        wait_cs_fall(n, 200);
        repeat (60) @(posedge clk);
        #1;
        check("overrun_before_first_drop", {31'h0, overrun}, 32'd0);
        repeat (6) @(posedge clk);
        #1;
        check("overrun_after_first_drop", {31'h0, overrun}, 32'd1);
        wait_cs_fall(n, 200);
        repeat (70) @(posedge clk);
        #1;
        check("held_valid", {31'h0, sample_valid}, 32'd1);
        @(negedge clk);
        sample_ready = 1'b1;
        wait_cs_fall(n, 200);
        repeat (70) @(posedge clk);
        #1;
        check("overrun_sticky", {31'h0, overrun}, 32'd1);
        @(negedge clk);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        #1;
        check("overrun_cleared", {31'h0, overrun}, 32'd0);

        // Lock loss during SCLK pulse 7 of the next frame.
        act_q.push_back(2);
        wait_cs_fall(n, 200);
        falls  = 0;
        c      = 0;
        prev_s = adc_sclk;
        while (falls < 7 && c < 100) begin
            @(posedge clk);
            #1;
            c++;
            if (prev_s && !adc_sclk) falls++;
            prev_s = adc_sclk;
        end
        check("reached_sclk_pulse_7", falls, 7);
        @(negedge clk);
        pll_lock = 1'b0;
        c = 0;
        while (c < 6) begin
            @(posedge clk);
            #1;
            c++;
            if (adc_cs_n) break;
        end
        check("cs_rise_after_lock_loss", c, 3);
        repeat (100) @(posedge clk);
        #1;
        check("running_after_lock_loss", {31'h0, running}, 32'd0);
        check("sclk_idle_after_lock_loss", {31'h0, adc_sclk}, 32'd1);
        @(negedge clk);
        pll_lock = 1'b1;
        wait_cs_fall(n, 2000);
        check("relock_to_cs_fall", n, LW + 3);

        // Sequence wrap with ready held high.
        adc_word = 16'h0ABC;
        for (int i = 0; i < 257; i++) wait_cs_fall(n, 200);
        repeat (80) @(posedge clk);
        #1;
        check("no_overrun_after_wrap", {31'h0, overrun}, 32'd0);
        check("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
